// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants, state type and access checks for the load/store unit
package lsu_pkg;

   localparam logic [2:0] LS_B  = 3'b000;
   localparam logic [2:0] LS_H  = 3'b001;
   localparam logic [2:0] LS_W  = 3'b010;
   localparam logic [2:0] LS_BU = 3'b100;
   localparam logic [2:0] LS_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } lsu_state_t;

   function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
      logic ill;
      if (is_store) begin
         ill = !(f3 == LS_B || f3 == LS_H || f3 == LS_W);
      end else begin
         ill = !(f3 == LS_B || f3 == LS_H || f3 == LS_W || f3 == LS_BU || f3 == LS_HU);
      end
      return ill;
   endfunction

   // Width comes from funct3[1:0]; the unsigned variants share the signed ones' alignment rule.
   function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] byte_off);
      logic mis;
      case (f3[1:0])
         2'b01:   mis = byte_off[0];
         2'b10:   mis = (byte_off != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_data_align.sv
// rtl/lsu_data_align.sv - combinational byte-lane steering for stores and extraction/extension for loads
module lsu_data_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  byte_off,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic [3:0]  wmask,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   logic [31:0] shifted;

   always_comb begin
      wmask     = 4'b0000;
      wdata     = 32'h0;
      load_data = 32'h0;
      shifted   = rdata >> {byte_off, 3'b000};

      case (funct3[1:0])
         2'b00: begin
            wmask = 4'b0001 << byte_off;
            wdata = {4{store_data[7:0]}};
         end
         2'b01: begin
            wmask = byte_off[1] ? 4'b1100 : 4'b0011;
            wdata = {2{store_data[15:0]}};
         end
         2'b10: begin
            wmask = 4'b1111;
            wdata = store_data;
         end
         default: ;
      endcase

      case (funct3)
         LS_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
         LS_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
         LS_W:    load_data = shifted;
         LS_BU:   load_data = {24'h0, shifted[7:0]};
         LS_HU:   load_data = {16'h0, shifted[15:0]};
         default: load_data = 32'h0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory stage: one load or store per start over a req/ready handshake
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            is_store,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] store_data,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [3:0]      mem_wmask,
   output logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            mem_ready,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] load_data,
   output logic            misaligned,
   output logic            illegal
);

   lsu_state_t      state_q, state_d;
   logic            is_store_q, is_store_d;
   logic [2:0]      funct3_q, funct3_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] store_data_q, store_data_d;
   logic [XLEN-1:0] load_data_q, load_data_d;
   logic            misaligned_q, misaligned_d;
   logic            illegal_q, illegal_d;

   logic            start_ill;
   logic            start_mis;
   logic [3:0]      al_wmask;
   logic [XLEN-1:0] al_wdata;
   logic [XLEN-1:0] al_load;
   logic            in_req;
   logic            in_done;

   lsu_data_align u_align (
      .funct3     (funct3_q),
      .byte_off   (addr_q[1:0]),
      .store_data (store_data_q),
      .rdata      (mem_rdata),
      .wmask      (al_wmask),
      .wdata      (al_wdata),
      .load_data  (al_load)
   );

   always_comb begin
      state_d      = state_q;
      is_store_d   = is_store_q;
      funct3_d     = funct3_q;
      addr_d       = addr_q;
      store_data_d = store_data_q;
      load_data_d  = load_data_q;
      misaligned_d = misaligned_q;
      illegal_d    = illegal_q;

      // Illegal width masks misalignment so only one flag reports per access.
      start_ill = f3_illegal(is_store, funct3);
      start_mis = !start_ill && f3_misaligned(funct3, addr[1:0]);

      case (state_q)
         IDLE: begin
            if (start) begin
               is_store_d   = is_store;
               funct3_d     = funct3;
               addr_d       = addr;
               store_data_d = store_data;
               load_data_d  = '0;
               illegal_d    = start_ill;
               misaligned_d = start_mis;
               state_d      = (start_ill || start_mis) ? DONE : REQ;
            end
         end
         REQ: begin
            if (mem_ready) begin
               if (!is_store_q) begin
                  load_data_d = al_load;
               end
               state_d = DONE;
            end
         end
         DONE: begin
            load_data_d  = '0;
            misaligned_d = 1'b0;
            illegal_d    = 1'b0;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         is_store_q   <= 1'b0;
         funct3_q     <= 3'b000;
         addr_q       <= '0;
         store_data_q <= '0;
         load_data_q  <= '0;
         misaligned_q <= 1'b0;
         illegal_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         is_store_q   <= is_store_d;
         funct3_q     <= funct3_d;
         addr_q       <= addr_d;
         store_data_q <= store_data_d;
         load_data_q  <= load_data_d;
         misaligned_q <= misaligned_d;
         illegal_q    <= illegal_d;
      end
   end

   assign in_req  = (state_q == REQ);
   assign in_done = (state_q == DONE);

   // Bus outputs are forced to zero outside REQ so idle cycles never show stale addresses.
   assign mem_req    = in_req;
   assign mem_we     = in_req && is_store_q;
   assign mem_addr   = in_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
   assign mem_wmask  = (in_req && is_store_q) ? al_wmask : 4'b0000;
   assign mem_wdata  = (in_req && is_store_q) ? al_wdata : '0;
   assign busy       = (state_q != IDLE);
   assign done       = in_done;
   assign load_data  = in_done ? load_data_q : '0;
   assign misaligned = in_done && misaligned_q;
   assign illegal    = in_done && illegal_q;

endmodule
